rand_share_arbiter: RTL and testbench



---
 rtl/rand_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_rand_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rand_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR; each grant carries a fresh byte, then the LFSR steps STEPS times.
// Optional RAND_LOCKUP_GUARD_EN: zero seeds and any all-zero LFSR state are replaced by SEED_RST.
module rand_share_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          STEPS    = 4,
  parameter logic [7:0]  SEED_RST = 8'h0F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         rand_data,
  input  logic               seed_load,
  input  logic [7:0]         seed_value,
  output logic               busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, ADVANCE} state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_winner;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [7:0]           r_rand;

  state_t               w_state_nxt;
  logic [7:0]           w_lfsr_nxt;
  logic [7:0]           w_lfsr_shift;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [IDX_W-1:0]     w_winner_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [7:0]           w_rand_nxt;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_found;
  logic [NUM_REQ-1:0]   w_onehot;

  // First request at or above the pointer wins; otherwise wrap to the lowest set bit.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k] && (k >= int'(r_ptr))) begin
        w_sel   = IDX_W'(k);
        w_found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k]) begin
        w_sel   = IDX_W'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_onehot     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_lfsr_shift = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // A reseed takes priority over the scheduled shift in the same cycle.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (seed_load) begin
`ifdef RAND_LOCKUP_GUARD_EN
      w_lfsr_nxt = (seed_value == 8'h00) ? SEED_RST : seed_value;
`else
      w_lfsr_nxt = seed_value;
`endif
    end
`ifdef RAND_LOCKUP_GUARD_EN
    else if (r_lfsr == 8'h00) begin
      w_lfsr_nxt = SEED_RST;
    end
`endif
    else if (r_state == ADVANCE) begin
      w_lfsr_nxt = w_lfsr_shift;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_winner_nxt = r_winner;
    w_cnt_nxt    = r_cnt;
    w_gnt_nxt    = '0;
    w_rand_nxt   = r_rand;
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_winner_nxt = w_sel;
          w_gnt_nxt    = w_onehot;
          w_rand_nxt   = r_lfsr;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        w_ptr_nxt   = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
        w_cnt_nxt   = CNT_W'(STEPS);
        w_state_nxt = ADVANCE;
      end
      ADVANCE: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_lfsr   <= SEED_RST;
      r_ptr    <= '0;
      r_winner <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_rand   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_ptr    <= w_ptr_nxt;
      r_winner <= w_winner_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rand   <= w_rand_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rand_data = r_rand;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Directed bench for rand_share_arbiter (NUM_REQ=4, STEPS=4, SEED_RST=8'h0F).
module tb_rand_share_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] rand_data;
  logic       seed_load;
  logic [7:0] seed_value;
  logic       busy;

  int n_pass;
  int n_total;

  rand_share_arbiter #(.NUM_REQ(4), .STEPS(4), .SEED_RST(8'h0F)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .gnt        (gnt),
    .rand_data  (rand_data),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req        = '0;
    seed_load  = 1'b0;
    seed_value = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++;
    if (rand_data !== 8'h00) $display("FAIL reset_rand: got %h want 00", rand_data); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++;
    if (rand_data !== 8'h0F) $display("FAIL single_rand: got %h want 0f", rand_data); else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL single_busy_issue: got %b want 1", busy); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_total++;
      if (gnt !== 4'b0000) $display("FAIL single_gnt_idle[%0d]: got %b want 0000", i, gnt); else n_pass++;
      n_total++;
      if (busy !== (i < 5)) $display("FAIL single_busy[%0d]: got %b want %b", i, busy, (i < 5)); else n_pass++;
    end
    n_total++;
    if (rand_data !== 8'h0F) $display("FAIL single_rand_hold: got %h want 0f", rand_data); else n_pass++;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    n_total++;
    if (rand_data !== 8'hFB) $display("FAIL single_rand_advanced: got %h want fb", rand_data); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [7:0] exp_r [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{8'h0F, 8'hFB, 8'hB7, 8'h7A, 8'hAE};
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_total++;
      if (gnt !== exp_g[g]) $display("FAIL rr_gnt[%0d]: got %b want %b", g, gnt, exp_g[g]); else n_pass++;
      n_total++;
      if (rand_data !== exp_r[g]) $display("FAIL rr_rand[%0d]: got %h want %h", g, rand_data, exp_r[g]); else n_pass++;
      if (g < 4) begin
        for (int i = 0; i < 5; i++) begin
          tick();
          n_total++;
          if (gnt !== 4'b0000) $display("FAIL rr_gap[%0d.%0d]: got %b want 0000", g, i, gnt); else n_pass++;
        end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    n_total++;
    if (gnt !== 4'b0100) $display("FAIL wrap_first: got %b want 0100", gnt); else n_pass++;
    req = 4'b0101;
    repeat (6) tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL wrap_second: got %b want 0001", gnt); else n_pass++;
    n_total++;
    if (rand_data !== 8'hFB) $display("FAIL wrap_second_rand: got %h want fb", rand_data); else n_pass++;
    repeat (6) tick();
    n_total++;
    if (gnt !== 4'b0100) $display("FAIL wrap_third: got %b want 0100", gnt); else n_pass++;
    n_total++;
    if (rand_data !== 8'hB7) $display("FAIL wrap_third_rand: got %h want b7", rand_data); else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_seed_load();
    do_reset();
    req = 4'b0001;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL seed_first_gnt: got %b want 0001", gnt); else n_pass++;
    tick();
    seed_load  = 1'b1;
    seed_value = 8'hA5;
    tick();
    seed_load  = 1'b0;
    seed_value = 8'h00;
    n_total++;
    if (busy !== 1'b1) $display("FAIL seed_busy: got %b want 1", busy); else n_pass++;
    repeat (3) tick();
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL seed_early_gnt: got %b want 0000", gnt); else n_pass++;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL seed_gnt_timing: got %b want 0001", gnt); else n_pass++;
    n_total++;
    if (rand_data !== 8'h2A) $display("FAIL seed_rand: got %h want 2a", rand_data); else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    tick();
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL midrst_pre_gnt: got %b want 0010", gnt); else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if (rand_data !== 8'h00) $display("FAIL midrst_rand: got %h want 00", rand_data); else n_pass++;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL midrst_gnt: got %b want 0000", gnt); else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL midrst_post_gnt: got %b want 0010", gnt); else n_pass++;
    n_total++;
    if (rand_data !== 8'h0F) $display("FAIL midrst_post_rand: got %h want 0f", rand_data); else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_zero_seed();
    logic [7:0] exp0;
    logic [7:0] exp1;
`ifdef RAND_LOCKUP_GUARD_EN
    exp0 = 8'h0F;
    exp1 = 8'hFB;
`else
    exp0 = 8'h00;
    exp1 = 8'h00;
`endif
    do_reset();
    seed_load  = 1'b1;
    seed_value = 8'h00;
    tick();
    seed_load = 1'b0;
    req = 4'b0001;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL zero_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++;
    if (rand_data !== exp0) $display("FAIL zero_rand0: got %h want %h", rand_data, exp0); else n_pass++;
    repeat (6) tick();
    n_total++;
    if (rand_data !== exp1) $display("FAIL zero_rand1: got %h want %h", rand_data, exp1); else n_pass++;
    req = 4'b0000;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b1;
    req        = '0;
    seed_load  = 1'b0;
    seed_value = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_seed_load();
    test_reset_mid();
    test_zero_seed();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
